prog_loader: RTL and testbench
==============================

# prog_loader

Program loader and 16x8 program memory for the bus-based CPU. A host pushes program bytes in over a valid/ready byte handshake while the loader holds the CPU in clear. Once loading finishes, the loader releases the CPU and serves the CPU's MAR-addressed memory reads onto the shared 8-bit tri-state bus. It is the write side of the CPU's read-only program memory and replaces the fixed ROM in the top level.

## Interface
Parameters:
- DEPTH, 16, number of program words
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W
- DATA_W, 8, word width; equals bus width

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle request to (re)enter loading
- host_data  in  DATA_W  program byte from host
- host_valid  in  1  host_data valid
- host_last  in  1  qualifies the current byte as the final one
- host_ready  out  1  loader accepts a byte this cycle
- low_cpu_clr  out  1  active-low clear to the CPU (program counter, MAR, IR, ACC, B, OUT registers)
- cpu_run  out  1  high while the CPU is released
- addr  in  ADDR_W  read address from MAR
- low_o_en  in  1  active-low read enable from the control sequencer
- data_out  inout  DATA_W  tri-state drive onto the CPU bus
- load_count  out  ADDR_W+1  bytes written in the current load, 0..16
- checksum  out  DATA_W  sum of the bytes accepted in the current load, modulo 256

## Operation
- States: IDLE, LOAD, DONE, RUN.
- Reset (clr=0):
  - state IDLE; all words 0; write pointer 0; load_count 0; checksum 0.
  - host_ready 0; low_cpu_clr 0; cpu_run 0; data_out Z.
- IDLE:
  - Waits for load_start, then goes to LOAD.
  - host_valid is ignored.
- Entering LOAD from any state:
  - Clear all 16 words, the write pointer, load_count and checksum in that same edge.
  - Drive low_cpu_clr 0 from that edge onward.
- LOAD:
  - host_ready = (state==LOAD) & ~load_start. This is the only combinational input-to-output path.
  - A byte is accepted on any edge where host_valid & host_ready.
  - On accept: mem[ptr] <= host_data; ptr <= ptr+1; load_count <= load_count+1; checksum <= checksum+host_data (8-bit wrap).
  - The pointer does not wrap. Accepting the byte at ptr=15, or any byte with host_last=1, moves to DONE.
  - Words that were not written stay 0.
- DONE:
  - Lasts one cycle with host_ready 0 and low_cpu_clr still 0, so the CPU sees at least one cleared edge after the final write.
  - Then goes to RUN.
- RUN:
  - low_cpu_clr 1, cpu_run 1, host_ready 0.
  - Read port: data_out = mem[addr] when low_o_en=0 & cpu_run=1; otherwise Z.
  - load_start goes to LOAD (the memory clear happens as above).
- Simultaneous events:
  - load_start together with host_valid in LOAD: restart wins and the byte is not accepted.
  - load_start in DONE: goes to LOAD.
- Reset mid-load: all state is discarded and the block returns to IDLE.

## Timing
- Read latency is zero: combinational from addr/low_o_en to data_out, valid within the same cycle. This matches the CPU's fetch timing.
- Write latency: a byte accepted at edge k is visible in mem after edge k. It only reaches the read port once in RUN.
- End of load:
  - Final accept at edge k: DONE after k, RUN after k+1.
  - low_cpu_clr rises after edge k+1.
- Restart from RUN at edge j: low_cpu_clr falls and cpu_run falls after edge j, and data_out is Z from that point.
- load_count and checksum are registered and update on the accept edge.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, RUN=2'd3)
  - the DEPTH, ADDR_W and DATA_W constants.
- Sub-module ram16_8bit: flop array with a synchronous write port, a synchronous clear-all, an asynchronous active-low reset, and a combinational read port.
- The top-level FSM, pointer, checksum and tri-state driver live in prog_loader.

## Test plan
- Reset: hold clr=0 with host_valid=1 -> host_ready 0, low_cpu_clr 0, cpu_run 0, data_out Z, load_count 0, checksum 0.
- Full load: load_start, then bytes 0x10..0x1F back-to-back, last byte not flagged:
  - DONE for one cycle, then RUN; load_count 16, checksum 0x78.
  - Reads at addr 0..15 with low_o_en=0 return 0x10..0x1F; low_o_en=1 gives Z.
- Early last: bytes 0xA1, 0xB2, 0xC3 with host_last on the third:
  - load_count 3, checksum 0x16.
  - addr 2 reads 0xC3; addr 3..15 read 0x00.
- Back-pressure: host_valid toggling every other cycle during LOAD -> only cycles with valid=1 are accepted, and the data order is preserved.
- Reload: in RUN, pulse load_start together with host_valid=1:
  - low_cpu_clr 0 after the edge; that byte is not accepted.
  - Memory reads back 0 once the new load completes with no bytes flagged beyond the first word.
- Reset mid-load: drive clr=0 after 5 accepts -> IDLE; after release, a fresh load of 1 byte 0x7E with last gives checksum 0x7E and addr 4 reads 0x00.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: geometry constants, FSM state
// encoding and the running-checksum helper.
package prog_loader_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  // Loader FSM states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Running checksum: plain byte sum that wraps modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] csum_add(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] data
  );
    return acc + data;
  endfunction

endpackage

// File: rtl/prog_loader_ram.sv
// 16x8 program storage: flop array with one synchronous write port, a
// synchronous clear-all that wipes every word in one edge, an asynchronous
// active-low reset and a combinational read port for zero-latency fetch.
module ram16_8bit
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = prog_loader_pkg::DEPTH,
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next memory image: clear-all has priority over a single-word write.
  always_comb begin
    mem_d = mem_q;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops; reset returns every word to zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port is purely combinational so the CPU sees data in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Program loader for the bus-based CPU. A host streams bytes in over a
// valid/ready handshake while the CPU is held in clear; after a one-cycle
// DONE guard the CPU is released and MAR-addressed reads are served onto the
// shared tri-state bus.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = prog_loader_pkg::DEPTH,
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  input  logic              host_last,
  output logic              host_ready,
  output logic              low_cpu_clr,
  output logic              cpu_run,
  input  logic [ADDR_W-1:0] addr,
  input  logic              low_o_en,
  inout  wire  [DATA_W-1:0] data_out,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum
);

  // The pointer is one bit wider than the address so it can never wrap;
  // the final word is detected explicitly instead.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PTR_ZERO = (ADDR_W+1)'(0);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              low_cpu_clr_q, low_cpu_clr_d;
  logic              cpu_run_q, cpu_run_d;

  logic              accept_s;
  logic              mem_clear_s;
  logic [DATA_W-1:0] rdata_s;

  // Restart always wins over a byte offered in the same cycle, which is why
  // load_start masks ready; this is the only input-to-output comb path.
  assign host_ready  = (state_q == ST_LOAD) & ~load_start;
  assign accept_s    = host_valid & host_ready;
  // Every load_start enters LOAD, and entering LOAD wipes the memory.
  assign mem_clear_s = load_start;

  // Next-state, pointer, counters and checksum for the loader FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    checksum_d   = checksum_q;
    if (load_start) begin
      state_d      = ST_LOAD;
      ptr_d        = PTR_ZERO;
      load_count_d = PTR_ZERO;
      checksum_d   = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (accept_s) begin
            ptr_d        = ptr_q + PTR_ONE;
            load_count_d = load_count_q + PTR_ONE;
            checksum_d   = csum_add(checksum_q, host_data);
            if (host_last || (ptr_q == LAST_PTR)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_DONE: begin
          // Guard cycle: the CPU sees one more cleared edge after the last write.
          state_d = ST_RUN;
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // CPU control follows the state being entered so it is registered.
    low_cpu_clr_d = (state_d == ST_RUN);
    cpu_run_d     = (state_d == ST_RUN);
  end

  // FSM state and registered outputs; reset discards any load in progress.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_ZERO;
      load_count_q  <= PTR_ZERO;
      checksum_q    <= {DATA_W{1'b0}};
      low_cpu_clr_q <= 1'b0;
      cpu_run_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_count_q  <= load_count_d;
      checksum_q    <= checksum_d;
      low_cpu_clr_q <= low_cpu_clr_d;
      cpu_run_q     <= cpu_run_d;
    end
  end

  ram16_8bit #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .clr     (clr),
    .clear_i (mem_clear_s),
    .we_i    (accept_s),
    .waddr_i (ptr_q[ADDR_W-1:0]),
    .wdata_i (host_data),
    .raddr_i (addr),
    .rdata_o (rdata_s)
  );

  assign low_cpu_clr = low_cpu_clr_q;
  assign cpu_run     = cpu_run_q;
  assign load_count  = load_count_q;
  assign checksum    = checksum_q;

  // Bus driver: only a released CPU with its read enable low sees memory.
  assign data_out = (cpu_run_q & ~low_o_en) ? rdata_s : {DATA_W{1'bz}};

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. The bus net is pulled up, so an undriven
// bus reads as 8'hFF; no expected memory value in these tests is 8'hFF.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       load_start;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_last;
  logic [3:0] addr;
  logic       low_o_en;
  wire        host_ready;
  wire        low_cpu_clr;
  wire        cpu_run;
  wire  [4:0] load_count;
  wire  [7:0] checksum;
  tri1  [7:0] data_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] BUS_Z = 32'h0000_00FF;

  typedef struct {
    logic [3:0] a;
    logic       oen;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t rd_tab [18];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk        (clk),
    .clr        (clr),
    .load_start (load_start),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_last  (host_last),
    .host_ready (host_ready),
    .low_cpu_clr(low_cpu_clr),
    .cpu_run    (cpu_run),
    .addr       (addr),
    .low_o_en   (low_o_en),
    .data_out   (data_out),
    .load_count (load_count),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock: through the rising edge, back to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    host_valid = 1'b1;
    host_data  = d;
    host_last  = last;
    #1 check("host_ready_on_push", 32'(host_ready), 32'd1);
    step();
  endtask

  task automatic idle_host();
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic oen, input logic [31:0] exp);
    addr     = a;
    low_o_en = oen;
    #1 check(name, 32'(data_out), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rd_tab[i] = '{a: 4'(i), oen: 1'b0, exp: 8'(8'h10 + i)};
    end
    rd_tab[16] = '{a: 4'd3,  oen: 1'b1, exp: 8'hFF};
    rd_tab[17] = '{a: 4'd15, oen: 1'b1, exp: 8'hFF};

    clr = 1'b0; load_start = 1'b0; host_valid = 1'b1; host_data = 8'h55;
    host_last = 1'b0; addr = 4'd0; low_o_en = 1'b0;

    // Reset state with valid high.
    repeat (3) @(negedge clk);
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_low_cpu_clr", 32'(low_cpu_clr), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_data_out_z", 32'(data_out), BUS_Z);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);

    // IDLE ignores host_valid.
    clr = 1'b1;
    step();
    check("idle_host_ready", 32'(host_ready), 32'd0);
    check("idle_no_accept", 32'(load_count), 32'd0);
    idle_host();

    // Full load 0x10..0x1F, last never flagged.
    pulse_start();
    #1 check("load_host_ready", 32'(host_ready), 32'd1);
    check("load_low_cpu_clr", 32'(low_cpu_clr), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    idle_host();
    check("full_done_ready", 32'(host_ready), 32'd0);
    check("full_done_clr", 32'(low_cpu_clr), 32'd0);
    check("full_done_run", 32'(cpu_run), 32'd0);
    check("full_count", 32'(load_count), 32'd16);
    check("full_checksum", 32'(checksum), 32'h78);
    rd("full_done_bus_z", 4'd0, 1'b0, BUS_Z);
    step();
    check("full_run_clr", 32'(low_cpu_clr), 32'd1);
    check("full_run_run", 32'(cpu_run), 32'd1);
    check("full_run_ready", 32'(host_ready), 32'd0);
    for (int i = 0; i < 18; i++) begin
      rd($sformatf("full_rd_%0d", i), rd_tab[i].a, rd_tab[i].oen, 32'(rd_tab[i].exp));
    end

    // Reload from RUN with a byte offered in the same cycle.
    low_o_en = 1'b0; addr = 4'd0;
    host_valid = 1'b1; host_data = 8'hEE; load_start = 1'b1;
    #1 check("reload_ready_masked", 32'(host_ready), 32'd0);
    @(negedge clk);
    step();
    load_start = 1'b0;
    idle_host();
    check("reload_clr_low", 32'(low_cpu_clr), 32'd0);
    check("reload_run_low", 32'(cpu_run), 32'd0);
    check("reload_count", 32'(load_count), 32'd0);
    check("reload_checksum", 32'(checksum), 32'd0);
    rd("reload_bus_z", 4'd0, 1'b0, BUS_Z);

    // Restart inside LOAD beats a simultaneous byte.
    push(8'h99, 1'b0);
    idle_host();
    check("restart_pre_count", 32'(load_count), 32'd1);
    host_valid = 1'b1; host_data = 8'h88; load_start = 1'b1;
    #1 check("restart_ready_masked", 32'(host_ready), 32'd0);
    @(negedge clk);
    step();
    load_start = 1'b0;
    idle_host();
    check("restart_count", 32'(load_count), 32'd0);
    check("restart_checksum", 32'(checksum), 32'd0);

    // Early last after three bytes.
    push(8'hA1, 1'b0);
    push(8'hB2, 1'b0);
    push(8'hC3, 1'b1);
    idle_host();
    check("early_count", 32'(load_count), 32'd3);
    check("early_checksum", 32'(checksum), 32'h16);
    check("early_done_clr", 32'(low_cpu_clr), 32'd0);
    step();
    check("early_run", 32'(cpu_run), 32'd1);
    rd("early_rd0", 4'd0, 1'b0, 32'hA1);
    rd("early_rd1", 4'd1, 1'b0, 32'hB2);
    rd("early_rd2", 4'd2, 1'b0, 32'hC3);
    for (int a = 3; a < 16; a++) rd($sformatf("early_rd%0d", a), 4'(a), 1'b0, 32'h00);

    // Back-pressure: valid every other cycle, data changing in between.
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      host_valid = (i % 2 == 0);
      host_data  = 8'(8'h40 + i);
      host_last  = (i == 6);
      if (host_valid) begin
        #1 check($sformatf("bp_ready_%0d", i), 32'(host_ready), 32'd1);
      end
      step();
    end
    idle_host();
    check("bp_count", 32'(load_count), 32'd4);
    check("bp_checksum", 32'(checksum), 32'h0C);
    step();
    rd("bp_rd0", 4'd0, 1'b0, 32'h40);
    rd("bp_rd1", 4'd1, 1'b0, 32'h42);
    rd("bp_rd2", 4'd2, 1'b0, 32'h44);
    rd("bp_rd3", 4'd3, 1'b0, 32'h46);
    rd("bp_rd4", 4'd4, 1'b0, 32'h00);

    // load_start while in DONE goes straight back to LOAD.
    pulse_start();
    push(8'h5A, 1'b1);
    idle_host();
    check("done_state_ready", 32'(host_ready), 32'd0);
    pulse_start();
    #1 check("done_restart_ready", 32'(host_ready), 32'd1);
    check("done_restart_count", 32'(load_count), 32'd0);
    check("done_restart_clr", 32'(low_cpu_clr), 32'd0);

    // Reset in the middle of a load.
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
    check("mid_count", 32'(load_count), 32'd5);
    check("mid_checksum", 32'(checksum), 32'h0F);
    clr = 1'b0;
    #1 check("mid_rst_count", 32'(load_count), 32'd0);
    check("mid_rst_checksum", 32'(checksum), 32'd0);
    check("mid_rst_ready", 32'(host_ready), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    step();
    check("mid_idle_ready", 32'(host_ready), 32'd0);
    check("mid_idle_count", 32'(load_count), 32'd0);
    idle_host();
    pulse_start();
    push(8'h7E, 1'b1);
    idle_host();
    step();
    check("fresh_run", 32'(cpu_run), 32'd1);
    check("fresh_count", 32'(load_count), 32'd1);
    check("fresh_checksum", 32'(checksum), 32'h7E);
    rd("fresh_rd4", 4'd4, 1'b0, 32'h00);
    rd("fresh_rd0", 4'd0, 1'b0, 32'h7E);
    rd("fresh_rd0_oen_hi", 4'd0, 1'b1, BUS_Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
